// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared types for the debounce/edge-qualification block.
//   deb_state_t : qualification FSM states. The two "stable" states hold the
//                 accepted level. The two "qual" states count consecutive
//                 samples of the opposite level before accepting it.
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    QUAL_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    QUAL_LOW    = 2'd3
  } deb_state_t;

endpackage : debounce_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter with a synchronous clear. When clr and inc are both
//   high in the same cycle, clr wins. The count stops at 2^WIDTH-1 and does
//   not wrap.
// Ports
//   clk    in   1      clock, posedge
//   n_rst  in   1      asynchronous active-low reset, clears count
//   inc    in   1      increment request
//   clr    in   1      synchronous clear, takes priority over inc
//   count  out  WIDTH  current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_COUNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge value of the others, whatever order the blocks run in.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/debounce_edge.sv
// -----------------------------------------------------------------------------
// debounce_edge
//   Qualifies an already-synchronized level. A change of level is accepted only
//   after STABLE_CYCLES consecutive identical samples. On acceptance, the
//   debounced level changes and a one-cycle rise or fall pulse is emitted.
//   Accepted rising edges and aborted qualifications (glitches) are counted
//   in saturating counters. A counter can be cleared synchronously.
// Parameters
//   STABLE_CYCLES  consecutive equal samples needed to accept a change (>= 2)
//   COUNT_WIDTH    width of edge_count and glitch_count
// Ports
//   clk           in   1            clock, posedge
//   n_rst         in   1            asynchronous active-low reset
//   sync_in       in   1            synchronized input level
//   clear         in   1            synchronous clear of both counters
//   debounced     out  1            qualified level (registered)
//   rise_pulse    out  1            1-cycle pulse on accepted 0->1 (registered)
//   fall_pulse    out  1            1-cycle pulse on accepted 1->0 (registered)
//   edge_count    out  COUNT_WIDTH  accepted rising edges, saturating
//   glitch_count  out  COUNT_WIDTH  aborted qualifications, saturating
// -----------------------------------------------------------------------------
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   sync_in,
  input  logic                   clear,
  output logic                   debounced,
  output logic                   rise_pulse,
  output logic                   fall_pulse,
  output logic [COUNT_WIDTH-1:0] edge_count,
  output logic [COUNT_WIDTH-1:0] glitch_count
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  // The qualifying sample that reaches this count is the last one needed.
  // The first sample (on entry to a qual state) already counts as 1.
  localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(STABLE_CYCLES - 1);

  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             debounced_q, debounced_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             edge_inc;
  logic             glitch_inc;

  // NOTE: every signal written here gets a default first. This means that no
  // path through the case statement leaves a value unassigned, which would
  // otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    debounced_d = debounced_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    edge_inc    = 1'b0;
    glitch_inc  = 1'b0;

    unique case (state_q)
      STABLE_LOW: begin
        if (sync_in) begin
          state_d = QUAL_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end

      QUAL_HIGH: begin
        if (!sync_in) begin
          state_d    = STABLE_LOW;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == ACCEPT_CNT) begin
          state_d     = STABLE_HIGH;
          cnt_d       = '0;
          debounced_d = 1'b1;
          rise_d      = 1'b1;
          edge_inc    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STABLE_HIGH: begin
        if (!sync_in) begin
          state_d = QUAL_LOW;
          cnt_d   = CNT_W'(1);
        end
      end

      QUAL_LOW: begin
        if (sync_in) begin
          state_d    = STABLE_HIGH;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == ACCEPT_CNT) begin
          state_d     = STABLE_LOW;
          cnt_d       = '0;
          debounced_d = 1'b0;
          fall_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= STABLE_LOW;
      cnt_q       <= '0;
      debounced_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      debounced_q <= debounced_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
    end
  end

  // The counters register their increment on the same edge that registers
  // the pulse, so a count changes together with the pulse that caused it.
  sat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_edge_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (edge_inc),
    .clr   (clear),
    .count (edge_count)
  );

  sat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_glitch_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (glitch_inc),
    .clr   (clear),
    .count (glitch_count)
  );

  assign debounced  = debounced_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule : debounce_edge

// File: tb/tb_debounce_edge.sv
// -----------------------------------------------------------------------------
// tb_debounce_edge
//   Directed bench for debounce_edge with STABLE_CYCLES=4, COUNT_WIDTH=4.
//   Inputs change 1 ns after a rising edge. Outputs are sampled 1 ns after
//   the edge that should have produced them.
// -----------------------------------------------------------------------------
module tb_debounce_edge;

  localparam int SC = 4;
  localparam int CW = 4;

  logic          clk;
  logic          n_rst;
  logic          sync_in;
  logic          clear;
  logic          debounced;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [CW-1:0] edge_count;
  logic [CW-1:0] glitch_count;

  int checks   = 0;
  int failures = 0;
  int exp_edges;

  debounce_edge #(
    .STABLE_CYCLES (SC),
    .COUNT_WIDTH   (CW)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .sync_in      (sync_in),
    .clear        (clear),
    .debounced    (debounced),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .edge_count   (edge_count),
    .glitch_count (glitch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply a sync_in value, then let one rising edge sample it.
  task automatic step(input logic v);
    sync_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic deb, input logic rise,
                            input logic fall);
    check({tag, ".deb"},  {7'd0, debounced},  {7'd0, deb});
    check({tag, ".rise"}, {7'd0, rise_pulse}, {7'd0, rise});
    check({tag, ".fall"}, {7'd0, fall_pulse}, {7'd0, fall});
  endtask

  initial begin
    n_rst   = 1'b0;
    sync_in = 1'b0;
    clear   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("rst_held", 1'b0, 1'b0, 1'b0);
    check("rst_held.edges",  {4'd0, edge_count},   8'd0);
    check("rst_held.glitch", {4'd0, glitch_count}, 8'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // 1. Idle low for 10 clocks.
    for (int i = 0; i < 10; i++) step(1'b0);
    check_outs("idle", 1'b0, 1'b0, 1'b0);
    check("idle.edges",  {4'd0, edge_count},   8'd0);
    check("idle.glitch", {4'd0, glitch_count}, 8'd0);

    // 2. A held rise is accepted on the 4th sampled-high edge.
    for (int i = 0; i < SC - 1; i++) begin
      step(1'b1);
      check_outs($sformatf("rise_wait%0d", i), 1'b0, 1'b0, 1'b0);
    end
    step(1'b1);
    check_outs("rise_acc", 1'b1, 1'b1, 1'b0);
    check("rise_acc.edges", {4'd0, edge_count}, 8'd1);
    step(1'b1);
    check_outs("rise_after", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < SC - 1; i++) begin
      step(1'b0);
      check_outs($sformatf("fall_wait%0d", i), 1'b1, 1'b0, 1'b0);
    end
    step(1'b0);
    check_outs("fall_acc", 1'b0, 1'b0, 1'b1);
    check("fall_acc.edges", {4'd0, edge_count}, 8'd1);
    step(1'b0);
    check_outs("fall_after", 1'b0, 1'b0, 1'b0);

    // 3. A 3-clock high glitch is rejected and counted.
    for (int i = 0; i < SC - 1; i++) begin
      step(1'b1);
      check_outs($sformatf("glitch_hi%0d", i), 1'b0, 1'b0, 1'b0);
    end
    step(1'b0);
    check_outs("glitch_abort", 1'b0, 1'b0, 1'b0);
    check("glitch.count", {4'd0, glitch_count}, 8'd1);
    check("glitch.edges", {4'd0, edge_count},   8'd1);

    // 4. Seventeen more qualified rise/fall cycles; edge_count saturates at 15.
    exp_edges = 1;
    for (int n = 0; n < 17; n++) begin
      repeat (SC - 1) step(1'b1);
      step(1'b1);
      if (exp_edges < 15) exp_edges++;
      check_outs($sformatf("sat_rise%0d", n), 1'b1, 1'b1, 1'b0);
      check($sformatf("sat_edges%0d", n), {4'd0, edge_count}, 8'(exp_edges));
      repeat (SC - 1) step(1'b0);
      step(1'b0);
      check_outs($sformatf("sat_fall%0d", n), 1'b0, 1'b0, 1'b1);
    end
    check("sat.final", {4'd0, edge_count}, 8'd15);

    // 5. clear on the accept edge: count ends at 0, pulse still fires.
    repeat (SC - 1) step(1'b1);
    clear = 1'b1;
    step(1'b1);
    clear = 1'b0;
    check_outs("clr_acc", 1'b1, 1'b1, 1'b0);
    check("clr_acc.edges",  {4'd0, edge_count},   8'd0);
    check("clr_acc.glitch", {4'd0, glitch_count}, 8'd0);
    step(1'b1);
    check("clr_after.edges", {4'd0, edge_count}, 8'd0);
    repeat (SC) step(1'b0);
    check_outs("clr_fall", 1'b0, 1'b0, 1'b1);
    // A 2-clock low glitch while high counts as a glitch.
    repeat (SC) step(1'b1);
    check("clr_rise2.edges", {4'd0, edge_count}, 8'd1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check_outs("lowglitch", 1'b1, 1'b0, 1'b0);
    check("lowglitch.count", {4'd0, glitch_count}, 8'd1);
    repeat (SC) step(1'b0);
    check_outs("pre_rst_fall", 1'b0, 1'b0, 1'b1);

    // 6. Asynchronous reset at cnt=2 in QUAL_HIGH discards progress.
    step(1'b1);
    step(1'b1);
    check("pre_rst.edges", {4'd0, edge_count}, 8'd1);
    n_rst = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 1'b0);
    check("async_rst.edges",  {4'd0, edge_count},   8'd0);
    check("async_rst.glitch", {4'd0, glitch_count}, 8'd0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < SC - 1; i++) begin
      step(1'b1);
      check_outs($sformatf("post_rst_wait%0d", i), 1'b0, 1'b0, 1'b0);
    end
    step(1'b1);
    check_outs("post_rst_acc", 1'b1, 1'b1, 1'b0);
    check("post_rst.edges", {4'd0, edge_count}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_debounce_edge
